// File: rtl/game_pkg.sv
// Shared types and constants for the per-frame game-logic scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

    localparam int TASK_BALL    = 0;
    localparam int TASK_PADDLE  = 1;
    localparam int TASK_COLLIDE = 2;
    localparam int TASK_SCORE   = 3;

    localparam int H_MAX     = 614;
    localparam int V_DISPLAY = 480;
    localparam int V_MAX     = 511;

endpackage

// File: rtl/window_event_decoder.sv
// Decodes the blanking-window open/close instants from the VGA scan counters.
module window_event_decoder
    import game_pkg::*;
#(
    parameter int WIN_START_LINE = V_DISPLAY,
    parameter int WIN_END_LINE   = 508
) (
    input  logic [9:0] counter_x,
    input  logic [8:0] counter_y,
    output logic       openEvt,
    output logic       closeEvt
);

    logic lineStart;

    assign lineStart = (counter_x == 10'd0);
    assign openEvt   = lineStart && (counter_y == 9'(WIN_START_LINE));
    assign closeEvt  = lineStart && (counter_y == 9'(WIN_END_LINE));

endmodule

// File: rtl/vblank_task_scheduler.sv
// Runs the enabled game-logic tasks one at a time, in index order, inside the
// vertical blanking window; each task gets a start/done handshake with a timeout.
module vblank_task_scheduler
    import game_pkg::*;
#(
    parameter int N_TASKS        = 4,
    parameter int WIN_START_LINE = V_DISPLAY,
    parameter int WIN_END_LINE   = 508,
    parameter int TIMEOUT        = 1024,
    parameter int FC_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         counter_x,
    input  logic [8:0]         counter_y,
    input  logic [N_TASKS-1:0] task_en,
    input  logic [N_TASKS-1:0] task_done,
    input  logic               clr_overrun,
    output logic [N_TASKS-1:0] task_start,
    output logic               busy,
    output logic               frame_tick,
    output logic               frame_done,
    output logic               timeout_err,
    output logic [2:0]         err_task,
    output logic               overrun,
    output logic [FC_W-1:0]    frame_count
);

    localparam int IW = $clog2(N_TASKS + 1);
    localparam int TW = $clog2(TIMEOUT);

    sched_state_t       state, stateNxt;
    logic [IW-1:0]      idx, idxNxt;
    logic [TW-1:0]      timer, timerNxt;
    logic [N_TASKS-1:0] startNxt;
    logic               tickNxt, doneNxt, toNxt, ovrSet;
    logic [2:0]         errNxt;
    logic [FC_W-1:0]    fcNxt;
    logic               curEn, curDone;
    logic               openEvt, closeEvt;

    window_event_decoder #(
        .WIN_START_LINE(WIN_START_LINE),
        .WIN_END_LINE  (WIN_END_LINE)
    ) u_winDec (
        .counter_x(counter_x),
        .counter_y(counter_y),
        .openEvt  (openEvt),
        .closeEvt (closeEvt)
    );

    always_comb begin
        stateNxt = state;
        idxNxt   = idx;
        timerNxt = timer;
        startNxt = task_start;
        tickNxt  = 1'b0;
        doneNxt  = 1'b0;
        toNxt    = 1'b0;
        ovrSet   = 1'b0;
        errNxt   = err_task;
        fcNxt    = frame_count;
        curEn    = 1'b0;
        curDone  = 1'b0;
        for (int i = 0; i < N_TASKS; i++) begin
            if (idx == IW'(i)) begin
                curEn   = task_en[i];
                curDone = task_done[i];
            end
        end

        case (state)
            IDLE: begin
                if (openEvt) begin
                    tickNxt  = 1'b1;
                    fcNxt    = frame_count + FC_W'(1);
                    idxNxt   = '0;
                    stateNxt = SCAN;
                end
            end
            SCAN: begin
                if (closeEvt) begin
                    startNxt = '0;
                    ovrSet   = 1'b1;
                    stateNxt = IDLE;
                end else if (idx == IW'(N_TASKS)) begin
                    doneNxt  = 1'b1;
                    stateNxt = IDLE;
                end else if (curEn) begin
                    startNxt = N_TASKS'(1) << idx;
                    timerNxt = '0;
                    stateNxt = WAIT;
                end else begin
                    idxNxt = idx + IW'(1);
                end
            end
            WAIT: begin
                // Window close beats a same-cycle done or timeout.
                if (closeEvt) begin
                    startNxt = '0;
                    ovrSet   = 1'b1;
                    stateNxt = IDLE;
                end else if (curDone) begin
                    startNxt = '0;
                    idxNxt   = idx + IW'(1);
                    stateNxt = SCAN;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    startNxt = '0;
                    toNxt    = 1'b1;
                    errNxt   = 3'(idx);
                    idxNxt   = idx + IW'(1);
                    stateNxt = SCAN;
                end else begin
                    timerNxt = timer + TW'(1);
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            timer       <= '0;
            task_start  <= '0;
            busy        <= 1'b0;
            frame_tick  <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            err_task    <= '0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= stateNxt;
            idx         <= idxNxt;
            timer       <= timerNxt;
            task_start  <= startNxt;
            busy        <= (stateNxt != IDLE);
            frame_tick  <= tickNxt;
            frame_done  <= doneNxt;
            timeout_err <= toNxt;
            err_task    <= errNxt;
            frame_count <= fcNxt;
            // A new overrun outranks a simultaneous clear request.
            if (ovrSet)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vblank_task_scheduler.sv
// Scenario bench for vblank_task_scheduler: a scoreboard of expected task starts
// is filled per scenario and drained by a per-cycle monitor of task_start.
module tb_vblank_task_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [3:0] task_en, task_done, task_start;
    logic       clr_overrun, busy, frame_tick, frame_done, timeout_err, overrun;
    logic [2:0] err_task;
    logic [7:0] frame_count;

    vblank_task_scheduler #(
        .N_TASKS(4), .WIN_START_LINE(480), .WIN_END_LINE(508), .TIMEOUT(1024), .FC_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .counter_x(cx), .counter_y(cy),
        .task_en(task_en), .task_done(task_done), .clr_overrun(clr_overrun),
        .task_start(task_start), .busy(busy), .frame_tick(frame_tick),
        .frame_done(frame_done), .timeout_err(timeout_err), .err_task(err_task),
        .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // idx: which start bit, len: cycles held high, gap: low cycles since the previous start/frame_tick
    typedef struct {int idx; int len; int gap;} exp_t;
    exp_t sb[$];

    int nChecks = 0, nFails = 0;
    int delay[4];
    bit stray = 0, closeWithDone = 0;
    int tickCnt = 0, fdCnt = 0, errCnt = 0, lastErr = -1;
    int cycNo = 0, lastFallCyc = 0, lastFdCyc = 0;
    int idleCnt = 0, curLen = 0, age = 0;
    bit curUnexp = 0, anyBusy = 0;
    logic [3:0] prevStart = '0;
    logic [7:0] expFc = '0;

    function automatic int oneIdx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One clock: sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cycNo++;
        if (busy) anyBusy = 1;
        if (frame_tick) tickCnt++;
        if (frame_done) begin fdCnt++; lastFdCyc = cycNo; end
        if (timeout_err) begin errCnt++; lastErr = int'(err_task); end
        nChecks++;
        if ($countones(task_start) > 1) begin
            nFails++; $display("FAIL onehot: task_start=%b, required at most one bit set", task_start);
        end
        if (task_start == 0) idleCnt++;
        if (task_start != 0 && prevStart == 0) begin
            curLen = 0; age = 0;
            nChecks++;
            if (sb.size() == 0) begin
                curUnexp = 1; nFails++;
                $display("FAIL unexpected_start: task_start=%b at cycle %0d, required none", task_start, cycNo);
            end else begin
                curUnexp = 0;
                if (oneIdx(task_start) != sb[0].idx || idleCnt != sb[0].gap) begin
                    nFails++;
                    $display("FAIL start_order: idx=%0d gap=%0d, required idx=%0d gap=%0d",
                             oneIdx(task_start), idleCnt, sb[0].idx, sb[0].gap);
                end
            end
            idleCnt = 0;
        end
        if (task_start != 0) begin curLen++; age++; end
        if (task_start == 0 && prevStart != 0) begin
            lastFallCyc = cycNo;
            if (!curUnexp && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                nChecks++;
                if (curLen != e.len) begin
                    nFails++; $display("FAIL start_len: task %0d high %0d cycles, required %0d", e.idx, curLen, e.len);
                end
            end
        end
        if (frame_tick) idleCnt = 0;
        prevStart = task_start;

        clr_overrun = 1'b0;
        task_done   = '0;
        if (cx == 10'd614) begin cx = '0; cy = (cy == 9'd511) ? 9'd0 : cy + 9'd1; end
        else cx = cx + 10'd1;
        for (int i = 0; i < 4; i++) begin
            if (task_start[i] && delay[i] != 0 && age == delay[i]) begin
                task_done[i] = 1'b1;
                if (closeWithDone) begin cx = '0; cy = 9'd508; clr_overrun = 1'b1; end
            end
        end
        if (stray && task_start != 0) task_done = task_done | ~task_start;
    endtask

    task automatic openFrame();
        cx = '0; cy = 9'd480;
        cyc();
    endtask

    task automatic waitIdle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin ok = 1; break; end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; task_en = '0; task_done = '0; clr_overrun = 0; cx = '0; cy = '0;
        delay = '{0, 0, 0, 0};
        repeat (2) cyc();
        nChecks++;
        if ({task_start, busy, frame_tick, frame_done, timeout_err, err_task, overrun, frame_count} !== 20'h0) begin
            nFails++; $display("FAIL reset_values: outputs=%h, required 0",
                {task_start, busy, frame_tick, frame_done, timeout_err, err_task, overrun, frame_count});
        end
        rst_n = 1;
        anyBusy = 0;
        repeat (5) cyc();
        nChecks++;
        if (anyBusy || task_start !== 4'h0) begin
            nFails++; $display("FAIL reset_idle: busy_seen=%0d start=%b, required idle", anyBusy, task_start);
        end
        expFc = '0;
    endtask

    task automatic test_all_tasks();
        int t0, f0; bit ok;
        task_en = 4'b1111; delay = '{10, 10, 10, 10};
        sb.push_back('{0, 10, 0}); sb.push_back('{1, 10, 1});
        sb.push_back('{2, 10, 1}); sb.push_back('{3, 10, 1});
        t0 = tickCnt; f0 = fdCnt;
        openFrame();
        waitIdle(1000, ok);
        expFc++;
        nChecks++; if (!ok) begin nFails++; $display("FAIL all_idle: busy=%0d, required 0 within budget", busy); end
        nChecks++; if (tickCnt - t0 != 1) begin nFails++; $display("FAIL all_tick: %0d ticks, required 1", tickCnt - t0); end
        nChecks++; if (fdCnt - f0 != 1) begin nFails++; $display("FAIL all_done: %0d frame_done, required 1", fdCnt - f0); end
        nChecks++; if (lastFdCyc - lastFallCyc != 1) begin
            nFails++; $display("FAIL all_done_lat: %0d, required 1", lastFdCyc - lastFallCyc); end
        nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL all_overrun: %b, required 0", overrun); end
        nChecks++; if (frame_count !== expFc) begin nFails++; $display("FAIL all_fc: %0d, required %0d", frame_count, expFc); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL all_sb: %0d starts missing, required 0", sb.size()); end
    endtask

    task automatic test_en_mask();
        int f0; bit ok;
        task_en = 4'b0101; delay = '{5, 5, 5, 5}; stray = 1;
        sb.push_back('{0, 5, 0}); sb.push_back('{2, 5, 2});
        f0 = fdCnt;
        openFrame();
        waitIdle(1000, ok);
        stray = 0; expFc++;
        nChecks++; if (!ok) begin nFails++; $display("FAIL mask_idle: busy=%0d, required 0", busy); end
        nChecks++; if (fdCnt - f0 != 1) begin nFails++; $display("FAIL mask_done: %0d, required 1", fdCnt - f0); end
        nChecks++; if (lastFdCyc - lastFallCyc != 2) begin
            nFails++; $display("FAIL mask_skip: %0d, required 2", lastFdCyc - lastFallCyc); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL mask_sb: %0d starts missing, required 0", sb.size()); end
        nChecks++; if (frame_count !== expFc) begin nFails++; $display("FAIL mask_fc: %0d, required %0d", frame_count, expFc); end
    endtask

    task automatic test_timeout();
        int t0, f0, e0; bit ok;
        task_en = 4'b1111; delay = '{10, 0, 10, 10};
        sb.push_back('{0, 10, 0}); sb.push_back('{1, 1024, 1});
        sb.push_back('{2, 10, 1}); sb.push_back('{3, 10, 1});
        t0 = tickCnt; f0 = fdCnt; e0 = errCnt;
        openFrame();
        repeat (200) cyc();
        cx = '0; cy = 9'd480;      // re-present the open instant while task 1 is waiting
        cyc();
        waitIdle(3000, ok);
        expFc++;
        nChecks++; if (!ok) begin nFails++; $display("FAIL to_idle: busy=%0d, required 0", busy); end
        nChecks++; if (tickCnt - t0 != 1) begin nFails++; $display("FAIL to_reopen: %0d ticks, required 1", tickCnt - t0); end
        nChecks++; if (errCnt - e0 != 1 || lastErr != 1) begin
            nFails++; $display("FAIL to_err: pulses=%0d err_task=%0d, required 1 and 1", errCnt - e0, lastErr); end
        nChecks++; if (fdCnt - f0 != 1) begin nFails++; $display("FAIL to_done: %0d, required 1", fdCnt - f0); end
        nChecks++; if (frame_count !== expFc) begin nFails++; $display("FAIL to_fc: %0d, required %0d", frame_count, expFc); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL to_sb: %0d starts missing, required 0", sb.size()); end
    endtask

    // Counters jump to late in line 507 once task 3 is running: close lands 16 cycles into it.
    task automatic test_close_overrun();
        int f0; bit ok, found;
        task_en = 4'b1111; delay = '{10, 10, 10, 0};
        sb.push_back('{0, 10, 0}); sb.push_back('{1, 10, 1});
        sb.push_back('{2, 10, 1}); sb.push_back('{3, 16, 1});
        f0 = fdCnt; found = 0;
        openFrame();
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (task_start[3]) begin found = 1; break; end
        end
        expFc++;
        nChecks++; if (!found) begin nFails++; $display("FAIL close_t3: task 3 start=%b, required 1", task_start[3]); end
        cx = 10'd600; cy = 9'd507;
        waitIdle(100, ok);
        nChecks++; if (!ok || task_start !== 4'h0) begin
            nFails++; $display("FAIL close_abort: busy=%0d start=%b, required 0 and 0", busy, task_start); end
        nChecks++; if (overrun !== 1'b1) begin nFails++; $display("FAIL close_ovr: %b, required 1", overrun); end
        nChecks++; if (fdCnt - f0 != 0) begin nFails++; $display("FAIL close_nodone: %0d, required 0", fdCnt - f0); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL close_sb: %0d starts missing, required 0", sb.size()); end
        clr_overrun = 1;
        cyc();
        nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL close_clr: %b, required 0", overrun); end
    endtask

    // close_evt, task_done[0] and clr_overrun all land on the same edge.
    task automatic test_close_with_done();
        int f0; bit ok;
        task_en = 4'b1111; delay = '{5, 10, 10, 10};
        sb.push_back('{0, 5, 0});
        f0 = fdCnt; closeWithDone = 1;
        openFrame();
        waitIdle(100, ok);
        closeWithDone = 0; expFc++;
        repeat (20) cyc();
        nChecks++; if (!ok) begin nFails++; $display("FAIL cwd_idle: busy=%0d, required 0", busy); end
        nChecks++; if (overrun !== 1'b1) begin nFails++; $display("FAIL cwd_ovr: %b, required 1", overrun); end
        nChecks++; if (fdCnt - f0 != 0) begin nFails++; $display("FAIL cwd_nodone: %0d, required 0", fdCnt - f0); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL cwd_sb: %0d starts missing, required 0", sb.size()); end
        cx = '0; cy = 9'd508;
        cyc();
        nChecks++; if (busy !== 1'b0 || overrun !== 1'b1 || task_start !== 4'h0) begin
            nFails++; $display("FAIL close_in_idle: busy=%b ovr=%b start=%b, required 0 1 0", busy, overrun, task_start); end
        clr_overrun = 1;
        cyc();
        nChecks++; if (overrun !== 1'b0) begin nFails++; $display("FAIL cwd_clr: %b, required 0", overrun); end
    endtask

    task automatic test_wrap();
        int t0, f0; bit ok, allOk;
        task_en = 4'b0000; allOk = 1;
        t0 = tickCnt; f0 = fdCnt;
        for (int f = 0; f < 256; f++) begin
            openFrame();
            waitIdle(20, ok);
            if (!ok) allOk = 0;
            expFc++;
            if (expFc == 8'd0) begin
                nChecks++;
                if (frame_count !== 8'd0) begin nFails++; $display("FAIL wrap_zero: %0d, required 0", frame_count); end
            end
        end
        nChecks++; if (!allOk) begin nFails++; $display("FAIL wrap_idle: some frame stayed busy, required all idle"); end
        nChecks++; if (tickCnt - t0 != 256 || fdCnt - f0 != 256) begin
            nFails++; $display("FAIL wrap_pulses: ticks=%0d dones=%0d, required 256 256", tickCnt - t0, fdCnt - f0); end
        nChecks++; if (frame_count !== expFc) begin nFails++; $display("FAIL wrap_fc: %0d, required %0d", frame_count, expFc); end
    endtask

    task automatic test_reset_mid_wait();
        int t0; bit ok, found;
        task_en = 4'b1111; delay = '{0, 3, 3, 3};
        sb.push_back('{0, 50, 0});
        found = 0;
        openFrame();
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (task_start[0]) begin found = 1; break; end
        end
        repeat (49) cyc();
        nChecks++; if (!found) begin nFails++; $display("FAIL rst_t0: start=%b, required task 0 running", task_start); end
        rst_n = 0;
        #1;
        nChecks++; if (task_start !== 4'h0 || busy !== 1'b0 || frame_count !== 8'd0) begin
            nFails++; $display("FAIL rst_async: start=%b busy=%b fc=%0d, required 0 0 0", task_start, busy, frame_count); end
        expFc = '0;
        repeat (2) cyc();
        rst_n = 1;
        t0 = tickCnt; anyBusy = 0;
        repeat (100) cyc();
        nChecks++; if (tickCnt != t0 || anyBusy || task_start !== 4'h0) begin
            nFails++; $display("FAIL rst_quiet: ticks=%0d busy_seen=%0d, required 0 0", tickCnt - t0, anyBusy); end
        nChecks++; if (sb.size() != 0) begin nFails++; $display("FAIL rst_sb: %0d entries left, required 0", sb.size()); end
        delay = '{3, 3, 3, 3};
        sb.push_back('{0, 3, 0}); sb.push_back('{1, 3, 1});
        sb.push_back('{2, 3, 1}); sb.push_back('{3, 3, 1});
        openFrame();
        waitIdle(200, ok);
        expFc++;
        nChecks++; if (!ok || sb.size() != 0) begin
            nFails++; $display("FAIL rst_resume: busy=%0d left=%0d, required 0 0", busy, sb.size()); end
        nChecks++; if (frame_count !== expFc) begin nFails++; $display("FAIL rst_fc: %0d, required %0d", frame_count, expFc); end
    endtask

    initial begin
        test_reset();
        test_all_tasks();
        test_en_mask();
        test_timeout();
        test_close_overrun();
        test_close_with_done();
        test_wrap();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
